// File: rtl/frame_peak_detect.sv
// frame_peak_detect: per-frame, per-channel peak value, peak index and sum over N_PIXELS samples, with a valid/ready result port
module frame_peak_detect #(
  parameter int N_PIXELS = 128,
  parameter int DATA_W   = 12,
  parameter int IDX_W    = 7,
  parameter int SUM_W    = 19,
  parameter int MIN_PEAK = 64
) (
  input  logic              clk_20M,
  input  logic              reset_n,
  input  logic              frame_sync,
  input  logic              new_data,
  input  logic [DATA_W-1:0] pdata1,
  input  logic [DATA_W-1:0] pdata2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] peak1,
  output logic [DATA_W-1:0] peak2,
  output logic [IDX_W-1:0]  pidx1,
  output logic [IDX_W-1:0]  pidx2,
  output logic [SUM_W-1:0]  sum1,
  output logic [SUM_W-1:0]  sum2,
  output logic [1:0]        no_peak,
  output logic              overrun,
  output logic              frame_abort
);
  typedef enum logic {IDLE, ACQ} state_t;
  state_t state_q, state_d;
  logic fs1_q, fs2_q, fs3_q, nd_q;
  logic fs_rise, smp, acq, done, accept, new_ov;
  logic [IDX_W-1:0]  idx_q, idx_d, mi1_q, mi1_d, mi2_q, mi2_d;
  logic [DATA_W-1:0] max1_q, max1_d, max2_q, max2_d;
  logic [SUM_W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
  logic              valid_q, valid_d, ovr_q, ovr_d, abort_q;
  logic [DATA_W-1:0] pk1_q, pk2_q;
  logic [IDX_W-1:0]  px1_q, px2_q;
  logic [SUM_W-1:0]  sm1_q, sm2_q;
  logic [1:0]        np_q;
  assign fs_rise = fs2_q & ~fs3_q;
  assign smp     = new_data & ~nd_q;
  assign acq     = state_q == ACQ;
  assign accept  = valid_q & res_ready;
  assign new_ov  = done & valid_q & ~res_ready;
  assign valid_d = done | (valid_q & ~res_ready);
  assign ovr_d   = new_ov | (ovr_q & ~accept);
  // A restart clears the accumulators before the coincident sample is folded in as pixel 0.
  always_comb begin
    state_d = fs_rise ? ACQ : state_q;
    idx_d   = fs_rise ? '0 : idx_q;
    max1_d  = fs_rise ? '0 : max1_q;
    max2_d  = fs_rise ? '0 : max2_q;
    mi1_d   = fs_rise ? '0 : mi1_q;
    mi2_d   = fs_rise ? '0 : mi2_q;
    acc1_d  = fs_rise ? '0 : acc1_q;
    acc2_d  = fs_rise ? '0 : acc2_q;
    done    = 1'b0;
    if (smp && (fs_rise || acq)) begin
      acc1_d = acc1_d + SUM_W'(pdata1);
      acc2_d = acc2_d + SUM_W'(pdata2);
      mi1_d  = pdata1 > max1_d ? idx_d : mi1_d;
      max1_d = pdata1 > max1_d ? pdata1 : max1_d;
      mi2_d  = pdata2 > max2_d ? idx_d : mi2_d;
      max2_d = pdata2 > max2_d ? pdata2 : max2_d;
      done   = !fs_rise && idx_q == IDX_W'(N_PIXELS - 1);
      state_d = done ? IDLE : state_d;
      idx_d  = idx_d + 1'b1;
    end
  end
  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      {fs1_q, fs2_q, fs3_q, nd_q} <= '0;
      state_q <= IDLE;
      {idx_q, mi1_q, mi2_q, max1_q, max2_q, acc1_q, acc2_q} <= '0;
      {valid_q, ovr_q, abort_q} <= '0;
      {pk1_q, pk2_q, px1_q, px2_q, sm1_q, sm2_q, np_q} <= '0;
    end else begin
      {fs1_q, fs2_q, fs3_q, nd_q} <= {frame_sync, fs1_q, fs2_q, new_data};
      state_q <= state_d;
      {idx_q, mi1_q, mi2_q, max1_q, max2_q, acc1_q, acc2_q} <= {idx_d, mi1_d, mi2_d, max1_d, max2_d, acc1_d, acc2_d};
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abort_q <= fs_rise & acq;
      if (done) begin
        {pk1_q, pk2_q, px1_q, px2_q, sm1_q, sm2_q} <= {max1_d, max2_d, mi1_d, mi2_d, acc1_d, acc2_d};
        np_q <= {max2_d < DATA_W'(MIN_PEAK), max1_d < DATA_W'(MIN_PEAK)};
      end
    end
  end
  assign res_valid   = valid_q;
  assign overrun     = ovr_q;
  assign frame_abort = abort_q;
  assign peak1 = pk1_q;
  assign peak2 = pk2_q;
  assign pidx1 = px1_q;
  assign pidx2 = px2_q;
  assign sum1  = sm1_q;
  assign sum2  = sm2_q;
  assign no_peak = np_q;
endmodule

// File: tb/tb_frame_peak_detect.sv
// tb_frame_peak_detect: directed frames with hand-computed peak/index/sum/handshake expectations
module tb_frame_peak_detect;
  logic clk = 0, rst_n = 0, fs = 0, nd = 0, rdy = 0;
  logic [11:0] d1 = 0, d2 = 0;
  logic res_valid, overrun, frame_abort;
  logic [11:0] peak1, peak2;
  logic [6:0]  pidx1, pidx2;
  logic [18:0] sum1, sum2;
  logic [1:0]  no_peak;
  int nvec = 0, nerr = 0, aborts = 0;

  frame_peak_detect dut (
    .clk_20M(clk), .reset_n(rst_n), .frame_sync(fs), .new_data(nd),
    .pdata1(d1), .pdata2(d2), .res_valid(res_valid), .res_ready(rdy),
    .peak1(peak1), .peak2(peak2), .pidx1(pidx1), .pidx2(pidx2),
    .sum1(sum1), .sum2(sum2), .no_peak(no_peak), .overrun(overrun),
    .frame_abort(frame_abort)
  );

  always #25 clk = ~clk;
  always @(negedge clk) if (frame_abort === 1'b1) aborts++;

  task automatic send(input logic [11:0] a, input logic [11:0] b);
    @(negedge clk); d1 = a; d2 = b; nd = 1;
    @(negedge clk); nd = 0;
  endtask

  task automatic sync;
    @(negedge clk); fs = 1;
    repeat (4) @(negedge clk);
    fs = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0; rdy = 1;
    repeat (3) @(negedge clk);
    nvec++; if ({res_valid, peak1, peak2, pidx1, pidx2, sum1, sum2, no_peak, overrun, frame_abort} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got valid=%0d peak1=%0d sum1=%0d, want all 0", res_valid, peak1, sum1); end
    rst_n = 1;
  endtask

  task automatic test_ramp;
    sync;
    for (int i = 0; i < 128; i++) send(12'(i * 8), 12'(4095 - i * 8));
    nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL ramp_valid: got %0d want 1", res_valid); end
    nvec++; if (peak1 !== 12'd1016) begin nerr++; $display("FAIL ramp_peak1: got %0d want 1016", peak1); end
    nvec++; if (pidx1 !== 7'd127) begin nerr++; $display("FAIL ramp_pidx1: got %0d want 127", pidx1); end
    nvec++; if (sum1 !== 19'd65024) begin nerr++; $display("FAIL ramp_sum1: got %0d want 65024", sum1); end
    nvec++; if (peak2 !== 12'd4095) begin nerr++; $display("FAIL ramp_peak2: got %0d want 4095", peak2); end
    nvec++; if (pidx2 !== 7'd0) begin nerr++; $display("FAIL ramp_pidx2: got %0d want 0", pidx2); end
    nvec++; if (sum2 !== 19'd459136) begin nerr++; $display("FAIL ramp_sum2: got %0d want 459136", sum2); end
    nvec++; if (no_peak !== 2'b00) begin nerr++; $display("FAIL ramp_no_peak: got %b want 00", no_peak); end
    @(negedge clk);
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL ramp_valid_pulse: got %0d want 0", res_valid); end
    nvec++; if (peak1 !== 12'd1016) begin nerr++; $display("FAIL ramp_hold_peak1: got %0d want 1016", peak1); end
  endtask

  task automatic test_tie;
    sync;
    for (int i = 0; i < 128; i++) send((i == 10 || i == 90) ? 12'd900 : 12'd500, 12'd30);
    nvec++; if (peak1 !== 12'd900) begin nerr++; $display("FAIL tie_peak1: got %0d want 900", peak1); end
    nvec++; if (pidx1 !== 7'd10) begin nerr++; $display("FAIL tie_pidx1: got %0d want 10", pidx1); end
    nvec++; if (sum1 !== 19'd64800) begin nerr++; $display("FAIL tie_sum1: got %0d want 64800", sum1); end
    nvec++; if (peak2 !== 12'd30) begin nerr++; $display("FAIL tie_peak2: got %0d want 30", peak2); end
    nvec++; if (pidx2 !== 7'd0) begin nerr++; $display("FAIL tie_pidx2: got %0d want 0", pidx2); end
    nvec++; if (sum2 !== 19'd3840) begin nerr++; $display("FAIL tie_sum2: got %0d want 3840", sum2); end
    nvec++; if (no_peak !== 2'b10) begin nerr++; $display("FAIL tie_no_peak: got %b want 10", no_peak); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rdy = 0;
    sync;
    for (int i = 0; i < 128; i++) send(12'd100, 12'd50);
    nvec++; if (res_valid !== 1'b1 || peak1 !== 12'd100) begin nerr++; $display("FAIL bp_frame1: got valid=%0d peak1=%0d want 1/100", res_valid, peak1); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL bp_no_overrun: got %0d want 0", overrun); end
    sync;
    nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid: got %0d want 1", res_valid); end
    for (int i = 0; i < 128; i++) send(12'd200, 12'd50);
    nvec++; if (peak1 !== 12'd200 || sum1 !== 19'd25600) begin nerr++; $display("FAIL bp_frame2: got peak1=%0d sum1=%0d want 200/25600", peak1, sum1); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL bp_overrun: got %0d want 1", overrun); end
    nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid2: got %0d want 1", res_valid); end
    rdy = 1;
    @(negedge clk);
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL bp_accept_valid: got %0d want 0", res_valid); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL bp_overrun_clear: got %0d want 0", overrun); end
    nvec++; if (peak1 !== 12'd200) begin nerr++; $display("FAIL bp_hold_after_accept: got %0d want 200", peak1); end
  endtask

  task automatic test_abort;
    int a0;
    a0 = aborts;
    sync;
    for (int i = 0; i < 50; i++) send(12'd9, 12'd9);
    sync;
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL abort_no_result: got %0d want 0", res_valid); end
    for (int i = 0; i < 128; i++) send(12'd7, 12'd7);
    nvec++; if (aborts - a0 !== 1) begin nerr++; $display("FAIL abort_pulses: got %0d want 1", aborts - a0); end
    nvec++; if (sum1 !== 19'd896 || peak1 !== 12'd7) begin nerr++; $display("FAIL abort_sum1: got sum1=%0d peak1=%0d want 896/7", sum1, peak1); end
    nvec++; if (no_peak !== 2'b11) begin nerr++; $display("FAIL abort_no_peak: got %b want 11", no_peak); end
    @(negedge clk);
  endtask

  task automatic test_coincident;
    int a0;
    a0 = aborts;
    @(negedge clk); fs = 1;
    @(negedge clk);
    @(negedge clk); d1 = 12'd4000; d2 = 12'd0; nd = 1;
    @(negedge clk); nd = 0;
    @(negedge clk); fs = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 127; i++) send(12'd0, 12'd0);
    nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL coin_valid: got %0d want 1", res_valid); end
    nvec++; if (peak1 !== 12'd4000 || pidx1 !== 7'd0) begin nerr++; $display("FAIL coin_peak1: got %0d@%0d want 4000@0", peak1, pidx1); end
    nvec++; if (sum1 !== 19'd4000) begin nerr++; $display("FAIL coin_sum1: got %0d want 4000", sum1); end
    nvec++; if (no_peak !== 2'b10) begin nerr++; $display("FAIL coin_no_peak: got %b want 10", no_peak); end
    nvec++; if (aborts !== a0) begin nerr++; $display("FAIL coin_abort: got %0d want %0d", aborts, a0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    sync;
    for (int i = 0; i < 60; i++) send(12'd300, 12'd300);
    rst_n = 0;
    @(negedge clk);
    nvec++; if ({res_valid, peak1, peak2, pidx1, pidx2, sum1, sum2, no_peak, overrun, frame_abort} !== '0) begin
      nerr++; $display("FAIL midreset_outputs: got peak1=%0d sum1=%0d, want 0", peak1, sum1); end
    rst_n = 1;
    for (int i = 0; i < 10; i++) send(12'd900, 12'd900);
    nvec++; if (res_valid !== 1'b0 || peak1 !== 12'd0) begin nerr++; $display("FAIL midreset_unsynced: got valid=%0d peak1=%0d want 0/0", res_valid, peak1); end
    sync;
    for (int i = 0; i < 128; i++) send(12'(i), 12'(127 - i));
    nvec++; if (peak1 !== 12'd127 || pidx1 !== 7'd127 || sum1 !== 19'd8128) begin
      nerr++; $display("FAIL midreset_ch1: got %0d@%0d sum %0d want 127@127 sum 8128", peak1, pidx1, sum1); end
    nvec++; if (peak2 !== 12'd127 || pidx2 !== 7'd0 || sum2 !== 19'd8128) begin
      nerr++; $display("FAIL midreset_ch2: got %0d@%0d sum %0d want 127@0 sum 8128", peak2, pidx2, sum2); end
    nvec++; if (res_valid !== 1'b1 || no_peak !== 2'b00) begin nerr++; $display("FAIL midreset_flags: got valid=%0d no_peak=%b want 1/00", res_valid, no_peak); end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_tie;
    test_backpressure;
    test_abort;
    test_coincident;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
